ser_stream: RTL and testbench

//  Parametrised next-generation serializer: WIDTH-bit parallel words in, one bit per clock out.

---
 rtl/ser_stream.sv | 230 +++++++++++++++++++++++
 tb/tb_ser_stream.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ser_stream.sv
// ---------------------------------------------------------------------------
// ser_stream -- parametrised parallel-to-serial converter, TX side of the
// SerDes link.
//
// A WIDTH-bit word is taken on a valid/ready handshake and sent one bit per
// clock on dout. A one-word holding buffer lets the next word wait while the
// current frame is shifting, so back-to-back frames leave no idle cycle
// between them.
//
// Build option:
//   SER_PARITY_EN  defined   -> each frame carries one extra bit after the
//                               data: even parity (^word) of the sent word.
//                  undefined -> frame is exactly WIDTH bits; no parity logic.
//
// Parameters:
//   WIDTH       parallel word width (>= 2)
//   MSB_FIRST   1: bit WIDTH-1 goes out first; 0: bit 0 goes out first
//   IDLE_LEVEL  dout level while no frame is being sent
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   synchronous, active-high
//   enable     in   1: run; 0: freeze all state, din_ready forced low
//   din        in   parallel word, sampled only on the handshake edge
//   din_valid  in   din holds a word to send
//   din_ready  out  word accepted on an edge where din_valid & din_ready
//   dout       out  serial data, registered
//   frame      out  high while dout carries the first bit of a frame
//   busy       out  high while a frame bit is on dout or the buffer is full
// ---------------------------------------------------------------------------
module ser_stream #(
  parameter int unsigned WIDTH      = 32,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             dout,
  output logic             frame,
  output logic             busy
);

  // -------------------------------------------------------------------------
  // Frame geometry
  // -------------------------------------------------------------------------
`ifdef SER_PARITY_EN
  localparam int unsigned FLEN = WIDTH + 1;
`else
  localparam int unsigned FLEN = WIDTH;
`endif

  // The counter holds the number of frame bits already placed on dout, so it
  // must be able to reach FLEN itself.
  localparam int unsigned       CNT_W    = $clog2(FLEN + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FLEN);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
`ifdef SER_PARITY_EN
  // Once WIDTH bits are out, the next bit on dout is the stored parity.
  localparam logic [CNT_W-1:0]  CNT_DATA = CNT_W'(WIDTH);
`endif

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  // -------------------------------------------------------------------------
  // Bit-order helpers: the bit that leaves next, and the shifter after one
  // bit has left.
  // -------------------------------------------------------------------------
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [0:0]       state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [WIDTH-1:0] shift_q,     shift_d;
  logic [WIDTH-1:0] hold_q,      hold_d;
  logic             hold_full_q, hold_full_d;
  logic             dout_q,      dout_d;
  logic             frame_q,     frame_d;
`ifdef SER_PARITY_EN
  logic             par_q,       par_d;
`endif

  logic             accept;
  logic             load;
  logic [WIDTH-1:0] load_word;

  // Ready depends only on state and control inputs, never on din_valid, so a
  // source may legally wait for ready before raising valid.
  assign din_ready = enable & ~reset & ~hold_full_q;
  assign accept    = din_valid & din_ready;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first; a path that
    // leaves one unassigned would infer a latch. Defaulting to the current
    // state is also what makes enable=0 a clean freeze.
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    dout_d      = dout_q;
    frame_d     = frame_q;
`ifdef SER_PARITY_EN
    par_d       = par_q;
`endif
    load        = 1'b0;
    load_word   = din;

    if (enable) begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            load = 1'b1;
          end
        end

        S_SHIFT: begin
          if (cnt_q != CNT_LAST) begin
            // Mid-frame: put the next bit on dout.
            cnt_d   = cnt_q + CNT_ONE;
            frame_d = 1'b0;
`ifdef SER_PARITY_EN
            if (cnt_q == CNT_DATA) begin
              dout_d = par_q;
            end else begin
              dout_d  = head_bit(shift_q);
              shift_d = advance(shift_q);
            end
`else
            dout_d  = head_bit(shift_q);
            shift_d = advance(shift_q);
`endif
            // A word arriving now waits in the holding buffer.
            if (accept) begin
              hold_d      = din;
              hold_full_d = 1'b1;
            end
          end else if (hold_full_q) begin
            // Last bit on dout and a word waiting: start it with no gap.
            load        = 1'b1;
            load_word   = hold_q;
            hold_full_d = 1'b0;
          end else if (accept) begin
            // Last bit on dout and a word arriving right now: also gapless,
            // the buffer is bypassed.
            load = 1'b1;
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
            dout_d  = IDLE_LEVEL;
            frame_d = 1'b0;
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // Starting a frame: the first bit goes straight to dout, the shifter keeps
    // the remaining bits. Parity is captured here so a later write to the
    // holding buffer cannot disturb the frame in flight.
    if (load) begin
      state_d = S_SHIFT;
      cnt_d   = CNT_ONE;
      dout_d  = head_bit(load_word);
      frame_d = 1'b1;
      shift_d = advance(load_word);
`ifdef SER_PARITY_EN
      par_d   = ^load_word;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Control and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments in clocked blocks, so every flop samples
    // the pre-edge values regardless of statement or block order.
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      hold_full_q <= 1'b0;
      dout_q      <= IDLE_LEVEL;
      frame_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_full_q <= hold_full_d;
      dout_q      <= dout_d;
      frame_q     <= frame_d;
    end
  end

  // -------------------------------------------------------------------------
  // Data registers
  // -------------------------------------------------------------------------
  // NOTE: the shifter, holding buffer and parity bit are not reset. Their
  // contents are only ever observed after a load, and hold_full_q / state_q
  // (which are reset) say whether they hold anything meaningful.
  always_ff @(posedge clock) begin
    shift_q <= shift_d;
    hold_q  <= hold_d;
`ifdef SER_PARITY_EN
    par_q   <= par_d;
`endif
  end

  assign dout  = dout_q;
  assign frame = frame_q;
  assign busy  = (state_q == S_SHIFT) | hold_full_q;

endmodule

// File: tb/tb_ser_stream.sv
// ---------------------------------------------------------------------------
// tb_ser_stream -- self-checking bench for ser_stream.
//
// Two instances share clock, reset and enable:
//   u32 : WIDTH=32, MSB first, idle level 0
//   u8  : WIDTH=8,  LSB first, idle level 1
// A reference model keeps, per instance, the current frame as a list of bits
// in send order plus an optional waiting word, and predicts dout, frame, busy
// and din_ready every cycle. Directed sequences and a vector table cover the
// documented corner cases; a random phase follows.
// ---------------------------------------------------------------------------
module tb_ser_stream;

`ifdef SER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FL32 = 32 + PAR;
  localparam int FL8  = 8 + PAR;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] din32;
  logic        v32;
  logic        rdy32, dout32, frame32, busy32;
  logic [7:0]  din8;
  logic        v8;
  logic        rdy8, dout8, frame8, busy8;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  ser_stream #(.WIDTH(32), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u32 (
    .clock(clk), .reset(rst), .enable(en),
    .din(din32), .din_valid(v32), .din_ready(rdy32),
    .dout(dout32), .frame(frame32), .busy(busy32)
  );

  ser_stream #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u8 (
    .clock(clk), .reset(rst), .enable(en),
    .din(din8), .din_valid(v8), .din_ready(rdy8),
    .dout(dout8), .frame(frame8), .busy(busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model (index 0 = u32, 1 = u8)
  // -------------------------------------------------------------------------
  function automatic int wid(input int k);  return (k == 0) ? 32 : 8; endfunction
  function automatic int flen(input int k); return wid(k) + PAR;      endfunction
  function automatic bit msb(input int k);  return (k == 0);          endfunction
  function automatic bit idle(input int k); return (k != 0);          endfunction

  logic [32:0] m_bits  [2];
  int          m_pos   [2];
  bit          m_act   [2];
  bit          m_hv    [2];
  logic [31:0] m_hw    [2];
  bit          m_dout  [2];
  bit          m_frame [2];

  // Frame as bits in transmission order: index 0 leaves first.
  function automatic logic [32:0] make_frame(input int k, input logic [31:0] w);
    logic [32:0] b;
    int          n;
    n = wid(k);
    b = '0;
    for (int i = 0; i < n; i++) b[i] = msb(k) ? w[n-1-i] : w[i];
`ifdef SER_PARITY_EN
    b[n] = ^w;
`endif
    return b;
  endfunction

  task automatic m_start(input int k, input logic [31:0] w);
    m_bits[k]  = make_frame(k, w);
    m_pos[k]   = 0;
    m_act[k]   = 1'b1;
    m_dout[k]  = m_bits[k][0];
    m_frame[k] = 1'b1;
  endtask

  task automatic model_step(input int k, input bit r, input bit e, input bit v, input logic [31:0] d);
    bit acc;
    if (r) begin
      m_act[k]   = 1'b0;
      m_hv[k]    = 1'b0;
      m_dout[k]  = idle(k);
      m_frame[k] = 1'b0;
    end else if (e) begin
      acc = v && !m_hv[k];
      if (m_act[k] && m_pos[k] < flen(k) - 1) begin
        m_pos[k]++;
        m_dout[k]  = m_bits[k][m_pos[k]];
        m_frame[k] = 1'b0;
        if (acc) begin
          m_hv[k] = 1'b1;
          m_hw[k] = d;
        end
      end else if (m_hv[k]) begin
        m_start(k, m_hw[k]);
        m_hv[k] = 1'b0;
      end else if (acc) begin
        m_start(k, d);
      end else begin
        m_act[k]   = 1'b0;
        m_dout[k]  = idle(k);
        m_frame[k] = 1'b0;
      end
    end
  endtask

  // Model advances on every edge; outputs are compared 2 time units later.
  always @(posedge clk) begin
    model_step(0, rst, en, v32, din32);
    model_step(1, rst, en, v8, {24'b0, din8});
    if (chk_en) begin
      #2;
      check("m32_dout",  dout32,  m_dout[0]);
      check("m32_frame", frame32, m_frame[0]);
      check("m32_busy",  busy32,  m_act[0] | m_hv[0]);
      check("m32_ready", rdy32,   en & ~rst & ~m_hv[0]);
      check("m8_dout",   dout8,   m_dout[1]);
      check("m8_frame",  frame8,  m_frame[1]);
      check("m8_busy",   busy8,   m_act[1] | m_hv[1]);
      check("m8_ready",  rdy8,    en & ~rst & ~m_hv[1]);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------------------------
  // Directed / table / random stimulus
  // -------------------------------------------------------------------------
  typedef struct {
    logic [7:0] word;
    logic [7:0] exp_seq;  // first transmitted bit in bit 7
    logic       exp_par;
  } vec_t;

  vec_t        vecs [6];
  logic [31:0] data;
  logic [31:0] got [3];
  logic [7:0]  seq;
  logic        par;
  logic        held;
  int          fcount, fbad, nbusy, frozen;
  bit          fire;

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called right after the negedge on which bit 0 of a u32 frame is visible;
  // returns after the last frame bit has been sampled.
  task automatic collect32(output logic [31:0] d, output logic p, output int nf);
    d  = '0;
    p  = 1'b0;
    nf = 0;
    for (int i = 0; i < FL32; i++) begin
      if (i > 0) @(negedge clk);
      if (i < 32) d = {d[30:0], dout32};
      else        p = dout32;
      nf += int'(frame32);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1;
    v32 = 1'b0; din32 = '0;
    v8  = 1'b0; din8  = '0;

    vecs[0] = '{8'hA5, 8'hA5, 1'b0};
    vecs[1] = '{8'h07, 8'hE0, 1'b1};
    vecs[2] = '{8'h03, 8'hC0, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 1'b1};
    vecs[4] = '{8'h3C, 8'h3C, 1'b0};
    vecs[5] = '{8'h01, 8'h80, 1'b1};

    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    // Reset state, reset still high.
    check("rst_dout32",  dout32,  1'b0);
    check("rst_frame32", frame32, 1'b0);
    check("rst_busy32",  busy32,  1'b0);
    check("rst_ready32", rdy32,   1'b0);
    check("rst_dout8",   dout8,   1'b1);
    check("rst_ready8",  rdy8,    1'b0);
    rst = 1'b0;
    idle_cycles(2);

    // --- single word, MSB first ---
    din32 = 32'h12345678; v32 = 1'b1;
    @(negedge clk);
    v32 = 1'b0;
    check("t1_first_frame", frame32, 1'b1);
    collect32(data, par, fcount);
    check("t1_data", data, 32'h12345678);
    check("t1_frame_count", fcount, 1);
`ifdef SER_PARITY_EN
    check("t1_parity", par, 1'b1);
`endif
    @(negedge clk);
    check("t1_busy_after", busy32, 1'b0);
    check("t1_idle_level", dout32, 1'b0);
    idle_cycles(3);

    // --- three words with valid held high: gapless ---
    fork
      begin : feed
        logic [31:0] words [3];
        words[0] = 32'hA1B2C3D4;
        words[1] = 32'h0F1E2D3C;
        words[2] = 32'h80000001;
        for (int w = 0; w < 3; w++) begin
          din32 = words[w]; v32 = 1'b1;
          fire = 1'b0;
          for (int t = 0; t < 200 && !fire; t++) begin
            fire = rdy32;
            @(negedge clk);
          end
          check("t2_accept", fire, 1'b1);
          if (w == 1) check("t2_ready_low_hold_full", rdy32, 1'b0);
        end
        v32 = 1'b0;
      end
      begin : collect
        fbad = 0; fcount = 0; nbusy = 0;
        got[0] = '0; got[1] = '0; got[2] = '0;
        @(negedge clk);
        for (int i = 0; i < 3 * FL32; i++) begin
          if (i > 0) @(negedge clk);
          if ((i % FL32) < 32) got[i / FL32] = {got[i / FL32][30:0], dout32};
          if (frame32 && (i % FL32) == 0) fcount++;
          if (frame32 && (i % FL32) != 0) fbad++;
          if (!busy32) nbusy++;
        end
      end
    join
    check("t2_word_a", got[0], 32'hA1B2C3D4);
    check("t2_word_b", got[1], 32'h0F1E2D3C);
    check("t2_word_c", got[2], 32'h80000001);
    check("t2_frame_starts", fcount, 3);
    check("t2_frame_stray", fbad, 0);
    check("t2_busy_gaps", nbusy, 0);
    @(negedge clk);
    check("t2_busy_after", busy32, 1'b0);
    idle_cycles(3);

    // --- enable low for 5 cycles after bit 10 ---
    din32 = 32'hDEADBEEF; v32 = 1'b1;
    @(negedge clk);
    v32 = 1'b0;
    data = '0; frozen = 0;
    for (int i = 0; i < 32; i++) begin
      if (i > 0) @(negedge clk);
      data = {data[30:0], dout32};
      if (i == 10) begin
        held = dout32;
        en = 1'b0;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          if (dout32 !== held || frame32 !== 1'b0 || busy32 !== 1'b1) frozen++;
        end
        check("t4_ready_while_disabled", rdy32, 1'b0);
        en = 1'b1;
      end
    end
    check("t4_frozen", frozen, 0);
    check("t4_data", data, 32'hDEADBEEF);
    idle_cycles(FL32 - 32 + 3);

    // --- reset at bit 15 with the holding buffer full ---
    din32 = 32'hCAFEF00D; v32 = 1'b1;
    @(negedge clk);
    din32 = 32'h0F0F1234;
    @(negedge clk);
    v32 = 1'b0;
    repeat (14) @(negedge clk);
    check("t5_busy_hold", busy32, 1'b1);
    check("t5_ready_hold", rdy32, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_dout",  dout32,  1'b0);
    check("t5_rst_frame", frame32, 1'b0);
    check("t5_rst_busy",  busy32,  1'b0);
    check("t5_rst_ready", rdy32,   1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("t5_hold_dropped", busy32, 1'b0);
    check("t5_ready_after", rdy32, 1'b1);
    din32 = 32'h55AA33CC; v32 = 1'b1;
    @(negedge clk);
    v32 = 1'b0;
    check("t5_fresh_frame", frame32, 1'b1);
    collect32(data, par, fcount);
    check("t5_fresh_data", data, 32'h55AA33CC);
    idle_cycles(3);

    // --- vector table on the 8-bit LSB-first instance ---
    for (int n = 0; n < 6; n++) begin
      din8 = vecs[n].word; v8 = 1'b1;
      @(negedge clk);
      v8 = 1'b0;
      check("tab_frame_first", frame8, 1'b1);
      seq = '0; par = 1'b0;
      for (int i = 0; i < FL8; i++) begin
        if (i > 0) @(negedge clk);
        if (i < 8) seq = {seq[6:0], dout8};
        else       par = dout8;
      end
      check("tab_seq", seq, vecs[n].exp_seq);
`ifdef SER_PARITY_EN
      check("tab_parity", par, vecs[n].exp_par);
`endif
      @(negedge clk);
      check("tab_idle_level", dout8, 1'b1);
      check("tab_busy_after", busy8, 1'b0);
      idle_cycles(1);
    end

    // --- randomised traffic against the model ---
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst   = ($urandom_range(0, 199) == 0);
      en    = ($urandom_range(0, 15) != 0);
      v32   = ($urandom_range(0, 3) != 0);
      din32 = $urandom;
      v8    = ($urandom_range(0, 2) != 0);
      din8  = 8'($urandom);
    end
    @(negedge clk);
    rst = 1'b0; en = 1'b1; v32 = 1'b0; v8 = 1'b0;
    idle_cycles(2 * FL32 + 4);
    check("end_busy32", busy32, 1'b0);
    check("end_busy8",  busy8,  1'b0);

    chk_en = 1'b0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
